act7_2by1_df: RTL and testbench

ACT7_2BY1_DF -- requirements
Module: act7_2by1_df

---
 rtl/act7_pkg.sv | 10 +
 rtl/act7_sel_mon.sv | 54 +++++
 rtl/act7_2by1_df.sv | 54 +++++
 tb/tb_act7_2by1_df.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/act7_pkg.sv
// act7_pkg: shared default constants for the act7 2:1 mux slice.
package act7_pkg;

  // Default data width of D0, D1 and Y.
  localparam int ACT7_WIDTH_DEF = 1;

  // Default width of the saturating select-change counter.
  localparam int ACT7_CNT_W_DEF = 8;

endpackage : act7_pkg

// File: rtl/act7_sel_mon.sv
// act7_sel_mon: edge-sampled select-change detector with a saturating
// change counter. The first edge after reset only primes s_prev, so a
// select that is already 1 at reset release is not reported as a change.
module act7_sel_mon
  import act7_pkg::*;
#(
  parameter int CNT_W = ACT7_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sel_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s_prev_d,  s_prev_q;
  logic             primed_d,  primed_q;
  logic             sel_chg_d, sel_chg_q;
  logic [CNT_W-1:0] sel_cnt_d, sel_cnt_q;

  // Next-state: sample S, flag a change once primed, count pulses without wrap.
  always_comb begin
    s_prev_d  = S;
    primed_d  = 1'b1;
    sel_chg_d = primed_q & (S != s_prev_q);
    if (sel_chg_q && (sel_cnt_q != CNT_MAX)) begin
      sel_cnt_d = sel_cnt_q + CNT_ONE;
    end else begin
      sel_cnt_d = sel_cnt_q;
    end
  end

  // State registers; reset clears everything, including a pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q  <= 1'b0;
      primed_q  <= 1'b0;
      sel_chg_q <= 1'b0;
      sel_cnt_q <= '0;
    end else begin
      s_prev_q  <= s_prev_d;
      primed_q  <= primed_d;
      sel_chg_q <= sel_chg_d;
      sel_cnt_q <= sel_cnt_d;
    end
  end

  assign sel_chg = sel_chg_q;
  assign sel_cnt = sel_cnt_q;

endmodule : act7_sel_mon

// File: rtl/act7_2by1_df.sv
// act7_2by1_df: 2:1 dataflow mux with select-change monitor.
// Optional feature macro: ACT7_REG_OUT_EN -- when defined, Y is registered
// (1-cycle latency, reset to 0); otherwise Y is a pure continuous mux.
// Positional order Y, D1, D0, S keeps legacy four-port instances working.
module act7_2by1_df
  import act7_pkg::*;
#(
  parameter int WIDTH = ACT7_WIDTH_DEF,
  parameter int CNT_W = ACT7_CNT_W_DEF
) (
  output logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D0,
  input  logic             S,
  input  logic             clk,
  input  logic             rst,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sel_cnt
);

`ifdef ACT7_REG_OUT_EN
  logic [WIDTH-1:0] y_d, y_q;

  // Mux result to be captured on the next edge.
  always_comb begin
    y_d = S ? D1 : D0;
  end

  // Output register; reset forces Y to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;
`else
  // Plain ?: so an unknown select yields X only where D0 and D1 disagree.
  assign Y = S ? D1 : D0;
`endif

  act7_sel_mon #(
    .CNT_W (CNT_W)
  ) u_sel_mon (
    .clk     (clk),
    .rst     (rst),
    .S       (S),
    .sel_chg (sel_chg),
    .sel_cnt (sel_cnt)
  );

endmodule : act7_2by1_df

// File: tb/tb_act7_2by1_df.sv
// tb_act7_2by1_df: self-checking bench for act7_2by1_df with three
// instances (WIDTH=1, WIDTH=8, CNT_W=2) sharing clk, rst and S.
module tb_act7_2by1_df;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       s;
  logic       d0_1, d1_1;
  logic [7:0] d0_8, d1_8;

  logic       y1, yc;
  logic [7:0] y8;
  logic       chg1, chg8, chgc;
  logic [7:0] cnt1, cnt8;
  logic [1:0] cntc;

  int checks;
  int errors;
  int pulses;

  act7_2by1_df #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .Y(y1), .D1(d1_1), .D0(d0_1), .S(s), .clk(clk), .rst(rst),
    .sel_chg(chg1), .sel_cnt(cnt1)
  );

  act7_2by1_df #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .Y(y8), .D1(d1_8), .D0(d0_8), .S(s), .clk(clk), .rst(rst),
    .sel_chg(chg8), .sel_cnt(cnt8)
  );

  act7_2by1_df #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .Y(yc), .D1(d1_1), .D0(d0_1), .S(s), .clk(clk), .rst(rst),
    .sel_chg(chgc), .sel_cnt(cntc)
  );

  // Clock with a stop control so combinational behaviour can be probed edge-free.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History of S values seen at clock edges since the last reset.
  bit         samp[$];
  logic       y1_m, yc_m;
  logic [7:0] y8_m;

  // Record what each edge sees; reset forgets the history.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp.delete();
      y1_m = 1'b0; yc_m = 1'b0; y8_m = 8'h00;
    end else begin
      samp.push_back(s);
      y1_m = s ? d1_1 : d0_1;
      yc_m = s ? d1_1 : d0_1;
      y8_m = s ? d1_8 : d0_8;
    end
  end

  // A pulse is visible when the two most recent samples differ.
  function automatic bit m_chg();
    int n = samp.size();
    return (n >= 2) && (samp[n-1] != samp[n-2]);
  endfunction

  // The count covers pulses that have already been visible for a full cycle.
  function automatic int m_cnt(input int maxv);
    int n = samp.size();
    int c = 0;
    for (int i = 1; i < n - 1; i++) begin
      if (samp[i] != samp[i-1]) c++;
    end
    return (c > maxv) ? maxv : c;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("w1.sel_chg", 32'(chg1), 32'(m_chg()));
    chk("w8.sel_chg", 32'(chg8), 32'(m_chg()));
    chk("c2.sel_chg", 32'(chgc), 32'(m_chg()));
    chk("w1.sel_cnt", 32'(cnt1), 32'(m_cnt(255)));
    chk("w8.sel_cnt", 32'(cnt8), 32'(m_cnt(255)));
    chk("c2.sel_cnt", 32'(cntc), 32'(m_cnt(3)));
`ifdef ACT7_REG_OUT_EN
    chk("w1.Y", 32'(y1), 32'(y1_m));
    chk("w8.Y", 32'(y8), 32'(y8_m));
    chk("c2.Y", 32'(yc), 32'(yc_m));
`else
    chk("w1.Y", 32'(y1), 32'(s ? d1_1 : d0_1));
    chk("w8.Y", 32'(y8), 32'(s ? d1_8 : d0_8));
    chk("c2.Y", 32'(yc), 32'(s ? d1_1 : d0_1));
`endif
    if (chg1) pulses++;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] sweep_tbl;
    checks = 0; errors = 0; pulses = 0;
    clk_en = 1'b1;
    rst = 1'b1; s = 1'b0;
    d0_1 = 1'b0; d1_1 = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00;
    repeat (3) step();
    chk("reset.sel_chg", 32'(chg1), 32'd0);
    chk("reset.sel_cnt", 32'(cnt1), 32'd0);
`ifdef ACT7_REG_OUT_EN
    chk("reset.Y", 32'(y8), 32'd0);
`endif

    // Release with S already high: first edge only samples.
    rst = 1'b0; s = 1'b1;
    d0_1 = 1'b0; d1_1 = 1'b1; d0_8 = 8'h5A; d1_8 = 8'hA5;
    step();
    chk("first_edge_no_chg", 32'(chg1), 32'd0);

    // Five consecutive edge-sampled toggles.
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      d0_8 = d0_8 + 8'h11;
      step();
    end
    chk("toggle5.sel_chg_pending", 32'(chg1), 32'd1);
    chk("toggle5.sel_cnt_lag", 32'(cnt1), 32'd4);
    chk("toggle5.c2_sat_early", 32'(cntc), 32'd3);
    step(); step();
    chk("toggle5.sel_cnt", 32'(cnt1), 32'd5);
    chk("toggle5.c2_sat", 32'(cntc), 32'd3);
    chk("toggle5.pulses", 32'(pulses), 32'd5);

    // Sub-period glitch between edges must not count.
    s = ~s; #1; s = ~s;
    repeat (3) step();
    chk("glitch.sel_cnt", 32'(cnt1), 32'd5);
    chk("glitch.pulses", 32'(pulses), 32'd5);

    // Second run: reset mid-operation with sel_cnt=4 and a pulse pending.
    rst = 1'b1; step();
    rst = 1'b0; s = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      step();
    end
    chk("midrst.pre_cnt", 32'(cnt1), 32'd4);
    chk("midrst.pre_chg", 32'(chg1), 32'd1);
    d0_8 = 8'h3C; d1_8 = 8'hC3;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.sel_cnt", 32'(cnt1), 32'd0);
    chk("midrst.sel_chg", 32'(chg1), 32'd0);
    chk("midrst.c2_cnt", 32'(cntc), 32'd0);
`ifdef ACT7_REG_OUT_EN
    chk("midrst.Y_reg", 32'(y8), 32'd0);
`else
    chk("midrst.Y_comb", 32'(y8), 32'h3C);
`endif
    step(); step();
    rst = 1'b0;
    step(); step();

`ifdef ACT7_REG_OUT_EN
    // Registered output: one-cycle latency, reset clears it.
    s = 1'b0; d0_1 = 1'b0; d1_1 = 1'b1;
    step();
    s = 1'b1;
    #1;
    chk("reg.Y_before_edge", 32'(y1), 32'd0);
    step();
    chk("reg.Y_after_edge", 32'(y1), 32'd1);
    rst = 1'b1;
    #1;
    chk("reg.Y_reset", 32'(y1), 32'd0);
    step();
    rst = 1'b0;
    step(); step();
`endif

    // Stop the clock (low) and probe the mux with no edges at all.
    @(negedge clk);
    clk_en = 1'b0;
    #1;
`ifndef ACT7_REG_OUT_EN
    // Index {S,D0,D1}: S=0 rows give D0 (0,0,1,1), S=1 rows give D1 (0,1,0,1).
    sweep_tbl = 8'b1010_1100;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      s = idx[2]; d0_1 = idx[1]; d1_1 = idx[0];
      #1;
      chk($sformatf("sweep%0d.Y", i), 32'(y1), 32'(sweep_tbl[i]));
    end
    d0_8 = 8'h5A; d1_8 = 8'hA5;
    s = 1'b0; #1;
    chk("w8.S0.Y", 32'(y8), 32'h5A);
    s = 1'b1; #1;
    chk("w8.S1.Y", 32'(y8), 32'hA5);
`else
    s = ~s; #1; s = ~s; #1;
`endif
    chk("noedge.sel_cnt", 32'(cnt1), 32'(m_cnt(255)));
    chk("noedge.sel_chg", 32'(chg1), 32'(m_chg()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_act7_2by1_df
